// File: rtl/decoder_pkg.sv
// Shared constants and helpers for the registered 2-to-4 line decoder.
package decoder_pkg;

  localparam int SEL_W   = 2;
  localparam int NUM_OUT = 4;

  localparam logic [SEL_W-1:0] CODE_Q = 2'b00;
  localparam logic [SEL_W-1:0] CODE_R = 2'b01;
  localparam logic [SEL_W-1:0] CODE_S = 2'b10;
  localparam logic [SEL_W-1:0] CODE_T = 2'b11;

  function automatic logic [NUM_OUT-1:0] onehot_of(input logic [SEL_W-1:0] code);
    logic [NUM_OUT-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational SEL_W -> 2^SEL_W one-hot decoder with enable; all zeros when disabled.
module onehot_dec #(
  parameter int SEL_W = 2,
  parameter int OUT_W = 1 << SEL_W
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/decoder_2to4.sv
// Registered 2-to-4 line decoder: {a,b} selects one of q/r/s/t, gated by en.
module decoder_2to4
  import decoder_pkg::*;
#(
  parameter bit OUT_ACTIVE_LOW = 1'b0,
  parameter bit REGISTERED     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic q,
  output logic r,
  output logic s,
  output logic t,
  output logic valid
);

  localparam logic [NUM_OUT-1:0] IDLE = OUT_ACTIVE_LOW ? '1 : '0;

  logic [SEL_W-1:0]   sel;
  logic [NUM_OUT-1:0] dec;
  logic [NUM_OUT-1:0] dec_pol;
  logic [NUM_OUT-1:0] out_vec;
  logic               valid_int;

  assign sel = {a, b};

  onehot_dec #(
    .SEL_W (SEL_W),
    .OUT_W (NUM_OUT)
  ) u_dec (
    .en     (en),
    .sel    (sel),
    .onehot (dec)
  );

  // A disabled decode is all zeros, so the XOR also yields the idle level.
  assign dec_pol = dec ^ IDLE;

  generate
    if (REGISTERED) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_vec   <= IDLE;
          valid_int <= 1'b0;
        end else begin
          out_vec   <= dec_pol;
          valid_int <= en;
        end
      end
    end else begin : g_bypass
      // Bring-up only: no clock involvement, reset still forces idle.
      always_comb begin
        out_vec   = rst_n ? dec_pol : IDLE;
        valid_int = rst_n & en;
      end
    end
  endgenerate

  assign {t, s, r, q} = out_vec;
  assign valid        = valid_int;

endmodule

// File: tb/tb_decoder_2to4.sv
// Scoreboard bench for decoder_2to4: active-high and active-low builds driven in parallel.
module tb_decoder_2to4;
  import decoder_pkg::*;

  logic clk;
  logic rst_n;
  logic en, a, b;
  logic q0, r0, s0, t0, valid0;
  logic q1, r1, s1, t1, valid1;

  int checks   = 0;
  int failures = 0;

  // Expected entries: {valid, t, s, r, q} for the active-high build.
  logic [4:0] sb_q[$];
  event       chk_ev;

  decoder_2to4 #(.OUT_ACTIVE_LOW(1'b0), .REGISTERED(1'b1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
    .q(q0), .r(r0), .s(s0), .t(t0), .valid(valid0)
  );

  decoder_2to4 #(.OUT_ACTIVE_LOW(1'b1), .REGISTERED(1'b1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
    .q(q1), .r(r1), .s(s1), .t(t1), .valid(valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: after each rising edge (or an explicit async probe) compare one entry.
  initial begin
    logic [4:0] exp_hi, exp_lo, act_hi, act_lo;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (sb_q.size() > 0) begin
        exp_hi = sb_q.pop_front();
        exp_lo = {exp_hi[4], ~exp_hi[3:0]};
        act_hi = {valid0, t0, s0, r0, q0};
        act_lo = {valid1, t1, s1, r1, q1};
        checks++;
        if (act_hi !== exp_hi) begin
          failures++;
          $display("FAIL active_high {valid,t,s,r,q} got=%b want=%b at %0t", act_hi, exp_hi, $time);
        end
        checks++;
        if (act_lo !== exp_lo) begin
          failures++;
          $display("FAIL active_low {valid,t,s,r,q} got=%b want=%b at %0t", act_lo, exp_lo, $time);
        end
      end
    end
  end

  task automatic step(input logic en_i, input logic [1:0] code, input logic [4:0] exp);
    @(negedge clk);
    en = en_i;
    {a, b} = code;
    sb_q.push_back(exp);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    a = 1'b0;
    b = 1'b0;

    // Reset held with random inputs: everything idle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en = 1'($urandom);
      a  = 1'($urandom);
      b  = 1'($urandom);
      sb_q.push_back(5'b0_0000);
    end

    // Release; first capture is 00 with en=1.
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    {a, b} = CODE_Q;
    sb_q.push_back(5'b1_0001);

    // Sweep.
    step(1'b1, CODE_Q, 5'b1_0001);
    step(1'b1, CODE_R, 5'b1_0010);
    step(1'b1, CODE_S, 5'b1_0100);
    step(1'b1, CODE_T, 5'b1_1000);

    // Hold 01 for three cycles.
    step(1'b1, CODE_R, 5'b1_0010);
    step(1'b1, CODE_R, 5'b1_0010);
    step(1'b1, CODE_R, 5'b1_0010);

    // Enable drop: t then idle; code changes together with en.
    step(1'b1, CODE_T, 5'b1_1000);
    step(1'b0, CODE_S, 5'b0_0000);
    step(1'b0, CODE_T, 5'b0_0000);

    // Re-enable to t, then reset pulse between edges.
    step(1'b1, CODE_T, 5'b1_1000);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb_q.push_back(5'b0_0000);
    ->chk_ev;
    #3;
    rst_n = 1'b1;

    // Post-reset operation, including the 10 polarity case on the active-low build.
    step(1'b1, CODE_S, 5'b1_0100);
    step(1'b1, CODE_Q, 5'b1_0001);
    step(1'b0, CODE_Q, 5'b0_0000);
    step(1'b1, CODE_S, 5'b1_0100);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
